fsm3_stim_driver: RTL and testbench
===================================

FSM3_STIM_DRIVER -- requirements
Module: fsm3_stim_driver

Interface
REQ-001 Parameter HOLD_W, default 4, width of the hold-cycle count field.
REQ-002 Parameter CNT_W, default 8, width of the mismatch error counter.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  request strobe from sequence source.
REQ-006 req_ready  output  1  driver can accept a request.
REQ-007 req_target  input  2  target state of the 3-state counter FSM: 0=s0, 1=s1, 2=s2; 3 illegal.
REQ-008 req_hold  input  HOLD_W  number of din=0 cycles to apply after reaching the target.
REQ-009 din  output  1  stimulus bit to the counter FSM under test.
REQ-010 dout_obs  input  1  observed FSM output.
REQ-011 shadow_state  output  2  model of the FSM state under test.
REQ-012 busy  output  1  high in every non-IDLE state.
REQ-013 done  output  1  one-cycle pulse when a request completes.
REQ-014 bad_req  output  1  sticky; an illegal target was received.
REQ-015 mismatch  output  1  sticky; dout_obs disagreed with the model.
REQ-016 err_cnt  output  CNT_W  count of mismatch cycles, saturating.

Function
REQ-017 Model: on each edge with rst low, shadow_state SHALL advance s0->s1->s2->s0 when din=1, and hold when din=0.
REQ-018 Expected output SHALL be 1 only when shadow_state=2; dout_obs SHALL be compared against it in every cycle where rst is low.
REQ-019 On a compare failure, mismatch SHALL set at the next edge, and err_cnt SHALL increment and saturate at 2^CNT_W-1.
REQ-020 Control FSM states: IDLE, STEP, HOLD, DONE; req_ready SHALL be high only in IDLE.
REQ-021 Accept: req_valid&&req_ready at an edge; the driver SHALL latch target and hold, and compute steps=(target-shadow_state) mod 3, in the range 0..2.
REQ-022 From IDLE on accept: steps>0 -> STEP; else hold>0 -> HOLD; else DONE.
REQ-023 STEP: din=1 every cycle; one step consumed per cycle; after the last step go to HOLD if hold>0, else DONE.
REQ-024 HOLD: din=0; stay for exactly hold cycles, then go to DONE.
REQ-025 DONE: done=1 for one cycle, din=0, then go to IDLE.
REQ-026 din SHALL be decoded only from registered state, glitch-free, and 0 outside STEP.
REQ-027 Latency: accept at edge k; din=1 in cycles k+1..k+steps; then hold cycles of din=0; done in the next cycle; req_ready in the cycle after that.
REQ-028 Target equal to current shadow_state: zero din pulses; hold and done behaviour unchanged.
REQ-029 Illegal target 3: the request SHALL be accepted, bad_req set, the request treated as steps=0 and hold=0, and done pulsed in the next cycle.
REQ-030 req_valid while busy SHALL be ignored; the source must hold req_valid until it sees req_ready.
REQ-031 Hold field all-ones SHALL give exactly 2^HOLD_W-1 HOLD cycles, with no wrap.

Reset
REQ-032 rst high at an edge SHALL force the following: IDLE, shadow_state=0, din=0, done=0, busy=0, bad_req=0, mismatch=0, err_cnt=0, req_ready=1 in the next cycle.
REQ-033 rst mid-STEP or mid-HOLD SHALL abort the request with no done pulse; the in-flight request is discarded.
REQ-034 No comparison SHALL occur in a cycle where rst is high.

Verification
REQ-035 Reset, then request target=2, hold=3 -> din=1 in cycles 1-2, din=0 in cycles 3-5, done in cycle 6; shadow_state=2; dout_obs=1 from cycle 3; mismatch=0.
REQ-036 From s2, request target=1, hold=0 -> two din pulses (s2->s0->s1); done in cycle 3; dout_obs=0; err_cnt=0.
REQ-037 Request target equal to current state, hold=0 -> no din pulse; done in cycle 1; busy high for exactly 1 cycle.
REQ-038 Request target=3 -> bad_req=1; done in the next cycle; din stays 0; shadow_state unchanged.
REQ-039 Force dout_obs=1 while shadow_state=0 for 300 cycles -> mismatch=1; err_cnt saturates at 255.
REQ-040 Assert rst during the 2nd STEP cycle -> din=0, shadow_state=0, no done pulse, req_ready=1; a new request is then accepted normally.

Source files
------------

// File: rtl/fsm3_stim_driver.sv
// Stimulus driver for a 3-state counter FSM: steps the DUT to a requested state,
// holds it for a number of idle cycles, and checks its output against a shadow model.
module fsm3_stim_driver #(
  parameter int HOLD_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_target,
  input  logic [HOLD_W-1:0] req_hold,
  output logic              din,
  input  logic              dout_obs,
  output logic [1:0]        shadow_state,
  output logic              busy,
  output logic              done,
  output logic              bad_req,
  output logic              mismatch,
  output logic [CNT_W-1:0]  err_cnt
);

  typedef enum logic [1:0] {IDLE, STEP, HOLD, DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_steps;
  logic [HOLD_W-1:0] r_hold;
  logic [1:0]        r_shadow;
  logic              r_bad;
  logic              r_mism;
  logic [CNT_W-1:0]  r_err;

  logic              w_accept;
  logic              w_illegal;
  logic [1:0]        w_steps;
  logic [HOLD_W-1:0] w_hold_eff;
  logic              w_exp;
  logic              w_fail;

  // Forward distance around the s0->s1->s2 ring.
  function automatic logic [1:0] steps_to(input logic [1:0] tgt, input logic [1:0] cur);
    logic [2:0] d;
    d = {1'b0, tgt} + 3'd3 - {1'b0, cur};
    if (d >= 3'd3) d = d - 3'd3;
    return d[1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_accept   = req_valid && (r_state == IDLE);
  assign w_illegal  = (req_target == 2'd3);
  assign w_steps    = w_illegal ? 2'd0 : steps_to(req_target, r_shadow);
  assign w_hold_eff = w_illegal ? '0 : req_hold;
  assign w_exp      = (r_shadow == 2'd2);
  assign w_fail     = (dout_obs != w_exp);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) begin
        if (w_steps != 2'd0)       w_next = STEP;
        else if (w_hold_eff != '0) w_next = HOLD;
        else                       w_next = DONE;
      end
      STEP: if (r_steps == 2'd1) w_next = (r_hold != '0) ? HOLD : DONE;
      HOLD: if (r_hold == HOLD_W'(1)) w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    din       = (r_state == STEP);
    busy      = (r_state != IDLE);
    done      = (r_state == DONE);
    req_ready = (r_state == IDLE);
  end

  // Request counters are only meaningful after an accept, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_steps <= w_steps;
      r_hold  <= w_hold_eff;
    end else begin
      if (r_state == STEP) r_steps <= r_steps - 2'd1;
      if (r_state == HOLD) r_hold  <= r_hold - HOLD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= 2'd0;
      r_bad    <= 1'b0;
      r_mism   <= 1'b0;
      r_err    <= '0;
    end else begin
      if (din) r_shadow <= (r_shadow == 2'd2) ? 2'd0 : r_shadow + 2'd1;
      if (w_accept && w_illegal) r_bad <= 1'b1;
      if (w_fail) begin
        r_mism <= 1'b1;
        r_err  <= sat_inc(r_err);
      end
    end
  end

  assign shadow_state = r_shadow;
  assign bad_req      = r_bad;
  assign mismatch     = r_mism;
  assign err_cnt      = r_err;

endmodule

// File: tb/tb_fsm3_stim_driver.sv
// Self-checking bench for fsm3_stim_driver: vector table, directed corner cases,
// and randomized requests against a request-level model of the ring counter.
module tb_fsm3_stim_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_target;
  logic [3:0] req_hold;
  logic       din;
  logic       dout_obs;
  logic [1:0] shadow_state;
  logic       busy;
  logic       done;
  logic       bad_req;
  logic       mismatch;
  logic [7:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int m_shadow = 0;
  int m_bad    = 0;
  bit obs_force = 0;
  bit obs_val   = 0;

  fsm3_stim_driver #(.HOLD_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_target(req_target), .req_hold(req_hold), .din(din), .dout_obs(dout_obs),
    .shadow_state(shadow_state), .busy(busy), .done(done), .bad_req(bad_req),
    .mismatch(mismatch), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] tgt;
    logic [3:0] hold;
    int         pulses;
    int         busy_cyc;
    int         shadow;
    int         bad;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Advance one clock; din_exp is the model's view of din in the cycle being left.
  task automatic tick(input bit din_exp);
    bit rst_at;
    rst_at = rst;
    @(posedge clk); #1;
    if (rst_at) begin
      m_shadow = 0;
      m_bad    = 0;
    end else if (din_exp) begin
      m_shadow = (m_shadow + 1) % 3;
    end
    dout_obs = obs_force ? obs_val : (m_shadow == 2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    tick(0);
    tick(0);
    rst = 1'b0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 50 && req_ready !== 1'b1; i++) tick(0);
    chk("wait_ready", req_ready, 1);
  endtask

  task automatic run_vec(input int idx);
    int pulses, busyc, stray, done_at;
    vec_t v;
    v = vt[idx];
    wait_ready();
    req_valid = 1'b1; req_target = v.tgt; req_hold = v.hold;
    tick(0);
    req_valid = 1'b0;
    pulses = 0; busyc = 0; stray = 0; done_at = -1;
    for (int c = 0; c < 40 && done_at < 0; c++) begin
      if (din) begin
        pulses++;
        if (c >= v.pulses) stray++;
      end
      if (busy) busyc++;
      if (done) done_at = c;
      tick(c < v.pulses);
    end
    chk($sformatf("vec%0d_pulses", idx), pulses, v.pulses);
    chk($sformatf("vec%0d_busy_cycles", idx), busyc, v.busy_cyc);
    chk($sformatf("vec%0d_done_cycle", idx), done_at, v.busy_cyc - 1);
    chk($sformatf("vec%0d_din_late", idx), stray, 0);
    chk($sformatf("vec%0d_shadow", idx), shadow_state, v.shadow);
    chk($sformatf("vec%0d_bad_req", idx), bad_req, v.bad);
    chk($sformatf("vec%0d_mismatch", idx), mismatch, 0);
    chk($sformatf("vec%0d_ready_after", idx), req_ready, 1);
  endtask

  // Request-level model: expected din/done pattern derived from ring distance and hold.
  task automatic run_req(input int t, input int h, input bit noise);
    int steps, he, total;
    bit exp_din, exp_done;
    wait_ready();
    steps = (t == 3) ? 0 : (t + 3 - m_shadow) % 3;
    he    = (t == 3) ? 0 : h;
    total = steps + he + 1;
    req_valid = 1'b1; req_target = 2'(t); req_hold = 4'(h);
    tick(0);
    req_valid = 1'b0;
    if (t == 3) m_bad = 1;
    for (int c = 0; c < total; c++) begin
      exp_din  = (c < steps);
      exp_done = (c == total - 1);
      chk("rq_din", din, exp_din);
      chk("rq_done", done, exp_done);
      chk("rq_busy", busy, 1);
      chk("rq_ready", req_ready, 0);
      chk("rq_shadow", shadow_state, m_shadow);
      if (noise) begin
        req_valid  = 1'($urandom_range(0, 1));
        req_target = 2'($urandom_range(0, 3));
        req_hold   = 4'($urandom_range(0, 15));
      end
      tick(exp_din);
    end
    req_valid = 1'b0;
    chk("rq_end_ready", req_ready, 1);
    chk("rq_end_busy", busy, 0);
    chk("rq_end_shadow", shadow_state, m_shadow);
    chk("rq_bad_req", bad_req, m_bad);
    chk("rq_mismatch", mismatch, 0);
    chk("rq_err_cnt", err_cnt, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_seen;
    rst = 1'b1; req_valid = 1'b0; req_target = 2'd0; req_hold = 4'd0; dout_obs = 1'b0;

    vt[0] = '{tgt: 2'd2, hold: 4'd3,  pulses: 2, busy_cyc: 6,  shadow: 2, bad: 0};
    vt[1] = '{tgt: 2'd1, hold: 4'd0,  pulses: 2, busy_cyc: 3,  shadow: 1, bad: 0};
    vt[2] = '{tgt: 2'd1, hold: 4'd0,  pulses: 0, busy_cyc: 1,  shadow: 1, bad: 0};
    vt[3] = '{tgt: 2'd3, hold: 4'd5,  pulses: 0, busy_cyc: 1,  shadow: 1, bad: 1};
    vt[4] = '{tgt: 2'd0, hold: 4'd15, pulses: 2, busy_cyc: 18, shadow: 0, bad: 1};
    vt[5] = '{tgt: 2'd1, hold: 4'd1,  pulses: 1, busy_cyc: 3,  shadow: 1, bad: 1};

    do_reset();
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_din", din, 0);
    chk("rst_done", done, 0);
    chk("rst_shadow", shadow_state, 0);
    chk("rst_bad_req", bad_req, 0);
    chk("rst_mismatch", mismatch, 0);
    chk("rst_err_cnt", err_cnt, 0);

    for (int i = 0; i < 6; i++) run_vec(i);

    // Forced wrong observation: error counter climbs then saturates.
    do_reset();
    obs_force = 1; obs_val = 1;
    dout_obs = 1'b1;
    for (int i = 0; i < 10; i++) tick(0);
    chk("obs_err_10", err_cnt, 10);
    chk("obs_mismatch", mismatch, 1);
    for (int i = 0; i < 290; i++) tick(0);
    chk("obs_err_sat", err_cnt, 255);
    chk("obs_mismatch_sticky", mismatch, 1);
    obs_force = 0;
    do_reset();
    chk("obs_clr_err", err_cnt, 0);
    chk("obs_clr_mismatch", mismatch, 0);

    // Reset during the second STEP cycle aborts the request silently.
    wait_ready();
    req_valid = 1'b1; req_target = 2'd2; req_hold = 4'd2;
    tick(0);
    req_valid = 1'b0;
    chk("abort_step1_din", din, 1);
    tick(1);
    chk("abort_step2_din", din, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("abort_din", din, 0);
    chk("abort_shadow", shadow_state, 0);
    chk("abort_ready", req_ready, 1);
    chk("abort_busy", busy, 0);
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) done_seen++;
      tick(0);
    end
    chk("abort_no_done", done_seen, 0);
    run_req(2, 1, 0);

    // Randomized requests, with noise on the request lines while busy.
    do_reset();
    for (int n = 0; n < 60; n++) begin
      int t, h;
      t = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
      h = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
      run_req(t, h, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) tick(0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
